// File: rtl/multi_queue_rr_scheduler.sv
`default_nettype none
// ============================================================================
// multi_queue_rr_scheduler : round-robin egress scheduler over QUEUE_COUNT
//   source queues with a one-entry registered output stage.
// Option macro : MULTI_QUEUE_RR_SCHEDULER_PACKET_LOCK_EN (contiguous packets)
// Revision     : 1.0
// ============================================================================
module multi_queue_rr_scheduler #(
  parameter  int QUEUE_COUNT = 4,
  parameter  int DATA_WIDTH  = 32,
  localparam int QID_WIDTH   = $clog2(QUEUE_COUNT)
) (
  input  logic                              clk,
  input  logic                              rst_n,
  input  logic [QUEUE_COUNT-1:0]            q_valid,
  input  logic [QUEUE_COUNT-1:0]            q_last,
  input  logic [QUEUE_COUNT*DATA_WIDTH-1:0] q_payload,
  output logic [QUEUE_COUNT-1:0]            q_ready,
  output logic                              out_valid,
  output logic [DATA_WIDTH-1:0]             out_payload,
  output logic                              out_last,
  output logic [QID_WIDTH-1:0]              out_qid,
  input  logic                              out_ready
);

  logic [QID_WIDTH-1:0]  rr_ptr_q,      rr_ptr_d;
  logic                  out_valid_q,   out_valid_d;
  logic [DATA_WIDTH-1:0] out_payload_q, out_payload_d;
  logic                  out_last_q,    out_last_d;
  logic [QID_WIDTH-1:0]  out_qid_q,     out_qid_d;

`ifdef MULTI_QUEUE_RR_SCHEDULER_PACKET_LOCK_EN
  typedef enum logic [0:0] {
    ST_IDLE   = 1'b0,
    ST_LOCKED = 1'b1
  } state_e;

  state_e               state_q,    state_d;
  logic [QID_WIDTH-1:0] lock_qid_q, lock_qid_d;
`endif

  logic                 load_en;
  logic                 grant_found;
  logic [QID_WIDTH-1:0] grant_idx;
  logic [QID_WIDTH-1:0] grant_next;
  logic                 xfer;

  // Modulo-QUEUE_COUNT add; operands never exceed 2*QUEUE_COUNT-2.
  function automatic logic [QID_WIDTH-1:0] wrap_add(input logic [QID_WIDTH-1:0] base,
                                                    input int                   off);
    int sum;
    sum = int'(base) + off;
    if (sum >= QUEUE_COUNT) begin
      sum = sum - QUEUE_COUNT;
    end
    return QID_WIDTH'(sum);
  endfunction

  assign load_en = !out_valid_q || out_ready;

  // Descending scan so the lowest offset from rr_ptr wins.
  always_comb begin
    grant_found = 1'b0;
    grant_idx   = '0;
    for (int k = QUEUE_COUNT - 1; k >= 0; k--) begin
      if (q_valid[wrap_add(rr_ptr_q, k)]) begin
        grant_found = 1'b1;
        grant_idx   = wrap_add(rr_ptr_q, k);
      end
    end
`ifdef MULTI_QUEUE_RR_SCHEDULER_PACKET_LOCK_EN
    if (state_q == ST_LOCKED) begin
      grant_found = 1'b1;
      grant_idx   = lock_qid_q;
    end
`endif
  end

  always_comb begin
    q_ready = '0;
    if (rst_n && load_en && grant_found) begin
      q_ready[grant_idx] = 1'b1;
    end
  end

  assign xfer       = |(q_valid & q_ready);
  assign grant_next = wrap_add(grant_idx, 1);

  always_comb begin
    out_valid_d   = out_valid_q;
    out_payload_d = out_payload_q;
    out_last_d    = out_last_q;
    out_qid_d     = out_qid_q;
    if (xfer) begin
      out_valid_d   = 1'b1;
      out_payload_d = q_payload[int'(grant_idx) * DATA_WIDTH +: DATA_WIDTH];
      out_last_d    = q_last[grant_idx];
      out_qid_d     = grant_idx;
    end else if (out_ready) begin
      out_valid_d   = 1'b0;
    end
  end

  always_comb begin
    rr_ptr_d = rr_ptr_q;
`ifdef MULTI_QUEUE_RR_SCHEDULER_PACKET_LOCK_EN
    state_d    = state_q;
    lock_qid_d = lock_qid_q;
    if (xfer) begin
      if (q_last[grant_idx]) begin
        state_d  = ST_IDLE;
        rr_ptr_d = grant_next;
      end else begin
        state_d    = ST_LOCKED;
        lock_qid_d = grant_idx;
      end
    end
`else
    // Per-flit arbitration: every transfer moves the pointer past the winner.
    if (xfer) begin
      rr_ptr_d = grant_next;
    end
`endif
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rr_ptr_q      <= '0;
      out_valid_q   <= 1'b0;
      out_payload_q <= '0;
      out_last_q    <= 1'b0;
      out_qid_q     <= '0;
`ifdef MULTI_QUEUE_RR_SCHEDULER_PACKET_LOCK_EN
      state_q       <= ST_IDLE;
      lock_qid_q    <= '0;
`endif
    end else begin
      rr_ptr_q      <= rr_ptr_d;
      out_valid_q   <= out_valid_d;
      out_payload_q <= out_payload_d;
      out_last_q    <= out_last_d;
      out_qid_q     <= out_qid_d;
`ifdef MULTI_QUEUE_RR_SCHEDULER_PACKET_LOCK_EN
      state_q       <= state_d;
      lock_qid_q    <= lock_qid_d;
`endif
    end
  end

  assign out_valid   = out_valid_q;
  assign out_payload = out_payload_q;
  assign out_last    = out_last_q;
  assign out_qid     = out_qid_q;

endmodule
`default_nettype wire

// File: tb/tb_multi_queue_rr_scheduler.sv
`default_nettype none
// ============================================================================
// tb_multi_queue_rr_scheduler : directed bench with a queue-level reference
//   model checked every cycle plus literal egress-order expectations.
// Revision : 1.0
// ============================================================================
module tb_multi_queue_rr_scheduler;

  localparam int QC = 4;
  localparam int DW = 32;
`ifdef MULTI_QUEUE_RR_SCHEDULER_PACKET_LOCK_EN
  localparam bit LOCK_MODE = 1'b1;
`else
  localparam bit LOCK_MODE = 1'b0;
`endif

  logic              clk = 1'b0;
  logic              rst_n;
  logic [QC-1:0]     q_valid;
  logic [QC-1:0]     q_last;
  logic [QC*DW-1:0]  q_payload;
  logic [QC-1:0]     q_ready;
  logic              out_valid;
  logic [DW-1:0]     out_payload;
  logic              out_last;
  logic [1:0]        out_qid;
  logic              out_ready;

  always #5 clk = ~clk;

  multi_queue_rr_scheduler #(.QUEUE_COUNT(QC), .DATA_WIDTH(DW)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .q_valid     (q_valid),
    .q_last      (q_last),
    .q_payload   (q_payload),
    .q_ready     (q_ready),
    .out_valid   (out_valid),
    .out_payload (out_payload),
    .out_last    (out_last),
    .out_qid     (out_qid),
    .out_ready   (out_ready)
  );

  int total = 0;
  int bad   = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // ---------------- reference model: who owns the link, what is held -------
  int            m_rr   = 0;
  bit            m_lock = 1'b0;
  int            m_lq   = 0;
  bit            m_ov   = 1'b0;
  logic [DW-1:0] m_pay  = '0;
  bit            m_last = 1'b0;
  int            m_qid  = 0;
  bit            check_en = 1'b0;

  function automatic int m_owner(output bit found);
    found = 1'b0;
    if (LOCK_MODE && m_lock) begin
      found = 1'b1;
      return m_lq;
    end
    for (int k = 0; k < QC; k++) begin
      if (q_valid[(m_rr + k) % QC]) begin
        found = 1'b1;
        return (m_rr + k) % QC;
      end
    end
    return 0;
  endfunction

  function automatic logic [QC-1:0] m_ready();
    bit            f;
    int            g;
    logic [QC-1:0] one;
    one = 1;
    g   = m_owner(f);
    if (rst_n && f && (!m_ov || out_ready)) return one << g;
    return '0;
  endfunction

  always @(posedge clk) begin
    bit            f;
    int            g;
    logic [QC-1:0] r;
    if (!rst_n) begin
      m_rr = 0; m_lock = 1'b0; m_lq = 0;
      m_ov = 1'b0; m_pay = '0; m_last = 1'b0; m_qid = 0;
      check_en = 1'b1;
    end else begin
      r = m_ready();
      g = m_owner(f);
      if (|(r & q_valid)) begin
        m_ov   = 1'b1;
        m_pay  = q_payload[g*DW +: DW];
        m_last = q_last[g];
        m_qid  = g;
        if (!LOCK_MODE || q_last[g]) begin
          m_lock = 1'b0;
          m_rr   = (g + 1) % QC;
        end else begin
          m_lock = 1'b1;
          m_lq   = g;
        end
      end else if (out_ready) begin
        m_ov = 1'b0;
      end
    end
  end

  logic [DW+1:0] egress[$];

  always @(negedge clk) begin
    if (check_en) begin
      chk("q_ready", q_ready, m_ready());
      chk("out_valid", out_valid, m_ov);
      if (m_ov) begin
        chk("out_payload", out_payload, m_pay);
        chk("out_last", out_last, m_last);
        chk("out_qid", out_qid, m_qid);
      end
      if (rst_n && out_valid && out_ready) egress.push_back({out_qid, out_payload});
    end
  end

  // ---------------- upstream queues ----------------------------------------
  logic [DW:0]   fq[QC][$];
  logic [QC-1:0] gate;

  task automatic apply_inputs();
    for (int i = 0; i < QC; i++) begin
      if (gate[i] && fq[i].size() > 0) begin
        q_valid[i]           = 1'b1;
        q_last[i]            = fq[i][0][DW];
        q_payload[i*DW +: DW] = fq[i][0][DW-1:0];
      end else begin
        q_valid[i]           = 1'b0;
        q_last[i]            = 1'b0;
        q_payload[i*DW +: DW] = '0;
      end
    end
  endtask

  task automatic push(input int q, input logic [DW-1:0] p, input bit l);
    fq[q].push_back({l, p});
  endtask

  function automatic bit all_empty();
    for (int i = 0; i < QC; i++) if (fq[i].size() != 0) return 1'b0;
    return 1'b1;
  endfunction

  task automatic tick(output logic [QC-1:0] rdy, output logic ov,
                      output logic [DW-1:0] pay, output logic [1:0] qid);
    logic [QC-1:0] pops;
    apply_inputs();
    @(negedge clk);
    rdy  = q_ready;
    ov   = out_valid;
    pay  = out_payload;
    qid  = out_qid;
    pops = q_valid & q_ready;
    @(posedge clk);
    #1;
    if (!rst_n) begin
      for (int i = 0; i < QC; i++) fq[i].delete();
    end else begin
      for (int i = 0; i < QC; i++) if (pops[i]) void'(fq[i].pop_front());
    end
    apply_inputs();
  endtask

  task automatic drain(input string name);
    int            n;
    logic [QC-1:0] r;
    logic          ov;
    logic [DW-1:0] p;
    logic [1:0]    qd;
    n    = 0;
    gate = '1;
    do begin
      tick(r, ov, p, qd);
      n++;
    end while ((!all_empty() || out_valid) && n < 60);
    chk({name, "_drain_done"}, (n < 60), 1);
  endtask

  task automatic chk_log(input string name, input int ex[$]);
    chk({name, "_beats"}, egress.size(), ex.size());
    foreach (ex[i]) begin
      if (i < egress.size()) chk($sformatf("%s_qid%0d", name, i), egress[i][DW +: 2], ex[i]);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [QC-1:0] r;
    logic          ov;
    logic [DW-1:0] p;
    logic [1:0]    qd;
    logic [QC-1:0] rseq[5];
    logic          vseq[5];
    int            ex[$];

    rst_n = 1'b0; out_ready = 1'b1; gate = '1;
    q_valid = '0; q_last = '0; q_payload = '0;

    // Reset with every queue requesting: no read strobe may escape.
    for (int i = 0; i < QC; i++) push(i, 32'h0000_0F00 + i, 1'b1);
    tick(r, ov, p, qd);
    chk("reset_qready", r, 4'b0000);
    rst_n = 1'b1;
    tick(r, ov, p, qd);
    chk("reset_out_valid", ov, 1'b0);
    chk("reset_out_payload", p, 32'h0);
    chk("reset_out_qid", qd, 2'd0);
    chk("reset_out_last", out_last, 1'b0);

    // All queues valid, single-flit packets.
    egress.delete();
    for (int i = 0; i < QC; i++) begin
      push(i, 32'h1000 + i*16, 1'b1);
      push(i, 32'h1001 + i*16, 1'b1);
    end
    for (int t = 0; t < 5; t++) begin
      tick(r, ov, p, qd);
      rseq[t] = r;
      vseq[t] = ov;
    end
    chk("rr_seq0", rseq[0], 4'b0001);
    chk("rr_seq1", rseq[1], 4'b0010);
    chk("rr_seq2", rseq[2], 4'b0100);
    chk("rr_seq3", rseq[3], 4'b1000);
    chk("rr_seq4", rseq[4], 4'b0001);
    for (int t = 1; t < 5; t++) chk($sformatf("rr_valid%0d", t), vseq[t], 1'b1);
    for (int i = 0; i < QC; i++) fq[i].delete();
    drain("rr");
    ex = '{0, 1, 2, 3, 0};
    chk_log("rr", ex);

    // Queue 2 three-flit packet, queue 0 joins one cycle later.
    egress.delete();
    push(2, 32'h2000, 1'b0); push(2, 32'h2001, 1'b0); push(2, 32'h2002, 1'b1);
    tick(r, ov, p, qd);
    push(0, 32'h2100, 1'b1);
    drain("pkt");
    if (LOCK_MODE) ex = '{2, 2, 2, 0}; else ex = '{2, 0, 2, 2};
    chk_log("pkt", ex);

    // Queue 1 pauses mid-packet while queue 3 waits.
    egress.delete();
    push(1, 32'h3000, 1'b0); push(1, 32'h3001, 1'b0); push(1, 32'h3002, 1'b1);
    push(3, 32'h3300, 1'b1);
    tick(r, ov, p, qd);
    gate[1] = 1'b0;
    tick(r, ov, p, qd);
    tick(r, ov, p, qd);
    gate = '1;
    drain("gap");
    if (LOCK_MODE) ex = '{1, 1, 1, 3}; else ex = '{3, 1, 1, 1};
    chk_log("gap", ex);

    // Sink stall holds the flit and blocks all reads.
    egress.delete();
    push(3, 32'hDEAD_BEEF, 1'b1);
    tick(r, ov, p, qd);
    push(0, 32'h0000_0A0A, 1'b1);
    out_ready = 1'b0;
    for (int t = 0; t < 4; t++) begin
      tick(r, ov, p, qd);
      chk($sformatf("stall_valid%0d", t), ov, 1'b1);
      chk($sformatf("stall_payload%0d", t), p, 32'hDEAD_BEEF);
      chk($sformatf("stall_qid%0d", t), qd, 2'd3);
      chk($sformatf("stall_qready%0d", t), r, 4'b0000);
    end
    out_ready = 1'b1;
    drain("stall");
    ex = '{3, 0};
    chk_log("stall", ex);
    if (egress.size() > 0) chk("stall_beat_payload", egress[0][DW-1:0], 32'hDEAD_BEEF);

    // Reset while queue 1 is mid-packet.
    push(1, 32'h5000, 1'b0); push(1, 32'h5001, 1'b0); push(1, 32'h5002, 1'b1);
    tick(r, ov, p, qd);
    rst_n = 1'b0;
    tick(r, ov, p, qd);
    chk("midrst_qready", r, 4'b0000);
    chk("midrst_held_valid", ov, 1'b1);
    rst_n = 1'b1;
    egress.delete();
    for (int i = 0; i < QC; i++) push(i, 32'h5100 + i, 1'b1);
    tick(r, ov, p, qd);
    chk("postrst_valid", ov, 1'b0);
    chk("postrst_qready", r, 4'b0001);
    drain("postrst");
    ex = '{0, 1, 2, 3};
    chk_log("postrst", ex);

    // Two concurrent two-flit packets.
    egress.delete();
    push(0, 32'h6000, 1'b0); push(0, 32'h6001, 1'b1);
    push(1, 32'h6100, 1'b0); push(1, 32'h6101, 1'b1);
    drain("ilv");
    if (LOCK_MODE) ex = '{0, 0, 1, 1}; else ex = '{0, 1, 0, 1};
    chk_log("ilv", ex);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
